// File: rtl/wb_ram_slave_if.sv
// Wishbone classic bus bundle between interconnect and RAM slave.
// Signal suffixes are from the slave's point of view.
interface wb_slave_bus_t;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        wb_rty_o;
  logic        wb_tgd_o;

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i,
    input  wb_adr_i, wb_dat_i, wb_sel_i,
    output wb_dat_o, wb_ack_o, wb_err_o,
    output wb_rty_o, wb_tgd_o
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i,
    output wb_adr_i, wb_dat_i, wb_sel_i,
    input  wb_dat_o, wb_ack_o, wb_err_o,
    input  wb_rty_o, wb_tgd_o
  );
endinterface

// File: rtl/wb_ram_slave.sv
// Wishbone classic slave fronting a word-addressed on-chip RAM.
// Single transfers, byte-lane writes, optional wait states.
module wb_ram_slave #(
  parameter int          MEM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic          clk,
  input  logic          rstn_i,
  wb_slave_bus_t.slave  wb_bus
);

  localparam int          AW   = $clog2(MEM_WORDS);
  localparam logic [31:0] SPAN = 32'(MEM_WORDS * 4);
  localparam logic [3:0]  WS_LOAD =
    (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [3:0]    cnt;
  logic [AW-1:0] idx_q;
  logic          bad_q;
  logic          we_q;
  logic [31:0]   dat_q;
  logic [3:0]    sel_q;

  logic          req;
  logic [31:0]   offset;
  logic [AW-1:0] in_idx;
  logic          in_bad;

  logic [AW-1:0] cur_idx;
  logic          cur_bad;
  logic          cur_we;
  logic [31:0]   cur_dat;
  logic [3:0]    cur_sel;
  logic          commit;

  logic [31:0]   mem [MEM_WORDS];
  logic [31:0]   dat_r;
  logic          unused_bits;

  assign req    = wb_bus.wb_cyc_i & wb_bus.wb_stb_i;
  assign offset = wb_bus.wb_adr_i - BASE_ADDR;
  assign in_idx = offset[AW+1:2];
  assign in_bad = (offset >= SPAN) |
                  (wb_bus.wb_adr_i[1:0] != 2'b00);

  assign unused_bits = ^{offset[31:AW+2], offset[1:0]};

  always_ff @(posedge clk) begin
    if (!rstn_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (req) begin
          state_nxt = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!wb_bus.wb_cyc_i) begin
          state_nxt = S_IDLE;
        end else if (cnt == 4'd0) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    wb_bus.wb_ack_o = 1'b0;
    wb_bus.wb_err_o = 1'b0;
    if (state == S_RESP) begin
      wb_bus.wb_ack_o = ~bad_q;
      wb_bus.wb_err_o = bad_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn_i) begin
      cnt   <= 4'd0;
      idx_q <= '0;
      bad_q <= 1'b0;
      we_q  <= 1'b0;
      dat_q <= 32'd0;
      sel_q <= 4'd0;
    end else if (state == S_IDLE && req) begin
      cnt   <= WS_LOAD;
      idx_q <= in_idx;
      bad_q <= in_bad;
      we_q  <= wb_bus.wb_we_i;
      dat_q <= wb_bus.wb_dat_i;
      sel_q <= wb_bus.wb_sel_i;
    end else if (state == S_WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Zero-wait transfers commit straight from the bus in IDLE.
  always_comb begin
    cur_idx = idx_q;
    cur_bad = bad_q;
    cur_we  = we_q;
    cur_dat = dat_q;
    cur_sel = sel_q;
    if (state == S_IDLE) begin
      cur_idx = in_idx;
      cur_bad = in_bad;
      cur_we  = wb_bus.wb_we_i;
      cur_dat = wb_bus.wb_dat_i;
      cur_sel = wb_bus.wb_sel_i;
    end
  end

  assign commit = rstn_i &
                  (state != S_RESP) &
                  (state_nxt == S_RESP) &
                  ~cur_bad;

  always_ff @(posedge clk) begin
    if (commit && cur_we) begin
      for (int n = 0; n < 4; n++) begin
        if (cur_sel[n]) begin
          mem[cur_idx][8*n +: 8] <= cur_dat[8*n +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn_i) begin
      dat_r <= 32'd0;
    end else if (commit && !cur_we) begin
      dat_r <= mem[cur_idx];
    end
  end

  assign wb_bus.wb_dat_o = dat_r;
  assign wb_bus.wb_rty_o = 1'b0;
  assign wb_bus.wb_tgd_o = 1'b0;

endmodule

// File: tb/tb_wb_ram_slave.sv
// Directed bench for wb_ram_slave: one zero-wait and one
// three-wait-state instance sharing a clock.
module tb_wb_ram_slave;

  localparam logic [31:0] B = 32'h1000_0000;

  logic clk;
  logic rst0;
  logic rst1;
  int   n_chk;
  int   n_pass;

  wb_slave_bus_t bus0 ();
  wb_slave_bus_t bus1 ();

  wb_ram_slave #(
    .MEM_WORDS   (64),
    .BASE_ADDR   (B),
    .WAIT_STATES (0)
  ) dut0 (
    .clk    (clk),
    .rstn_i (rst0),
    .wb_bus (bus0)
  );

  wb_ram_slave #(
    .MEM_WORDS   (64),
    .BASE_ADDR   (B),
    .WAIT_STATES (3)
  ) dut1 (
    .clk    (clk),
    .rstn_i (rst1),
    .wb_bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int d,
                       input logic cyc,
                       input logic stb,
                       input logic we,
                       input logic [31:0] adr,
                       input logic [31:0] dat,
                       input logic [3:0] sel);
    if (d == 0) begin
      bus0.wb_cyc_i = cyc;
      bus0.wb_stb_i = stb;
      bus0.wb_we_i  = we;
      bus0.wb_adr_i = adr;
      bus0.wb_dat_i = dat;
      bus0.wb_sel_i = sel;
    end else begin
      bus1.wb_cyc_i = cyc;
      bus1.wb_stb_i = stb;
      bus1.wb_we_i  = we;
      bus1.wb_adr_i = adr;
      bus1.wb_dat_i = dat;
      bus1.wb_sel_i = sel;
    end
  endtask

  function automatic logic ack_of(input int d);
    return (d == 0) ? bus0.wb_ack_o : bus1.wb_ack_o;
  endfunction

  function automatic logic err_of(input int d);
    return (d == 0) ? bus0.wb_err_o : bus1.wb_err_o;
  endfunction

  function automatic logic [31:0] dat_of(input int d);
    return (d == 0) ? bus0.wb_dat_o : bus1.wb_dat_o;
  endfunction

  // One transfer; checks latency and that the response is a single pulse.
  task automatic xfer(input int d,
                      input string tag,
                      input logic we,
                      input logic [31:0] adr,
                      input logic [31:0] dat,
                      input logic [3:0] sel,
                      output logic ack,
                      output logic err);
    int lat;
    ack = 1'b0;
    err = 1'b0;
    lat = 0;
    drive(d, 1'b1, 1'b1, we, adr, dat, sel);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ack_of(d) || err_of(d)) begin
        ack = ack_of(d);
        err = err_of(d);
        lat = i;
        break;
      end
    end
    drive(d, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    check({tag, "_lat"}, 32'(lat), (d == 0) ? 32'd1 : 32'd4);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(ack_of(d) | err_of(d)), 32'd0);
  endtask

  logic        a;
  logic        e;
  logic        flag;
  logic [31:0] pat;
  int          k;

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst0   = 1'b0;
    rst1   = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    repeat (3) @(negedge clk);
    check("rst0_ack", 32'(ack_of(0)), 32'd0);
    check("rst0_err", 32'(err_of(0)), 32'd0);
    check("rst0_dat", dat_of(0), 32'd0);
    check("rst0_rty", 32'(bus0.wb_rty_o), 32'd0);
    check("rst1_ack", 32'(ack_of(1)), 32'd0);
    check("rst1_dat", dat_of(1), 32'd0);
    rst0 = 1'b1;
    rst1 = 1'b1;
    @(negedge clk);

    // word write then read
    xfer(0, "wr10", 1'b1, B + 32'h10, 32'hDEAD_BEEF, 4'hF, a, e);
    check("wr10_ack", 32'(a), 32'd1);
    check("wr10_err", 32'(e), 32'd0);
    check("wr10_dat_hold", dat_of(0), 32'd0);
    xfer(0, "rd10", 1'b0, B + 32'h10, 32'd0, 4'hF, a, e);
    check("rd10_ack", 32'(a), 32'd1);
    check("rd10_dat", dat_of(0), 32'hDEAD_BEEF);

    // byte-lane merge
    xfer(0, "wr20", 1'b1, B + 32'h20, 32'h1122_3344, 4'hF, a, e);
    xfer(0, "wr20b", 1'b1, B + 32'h20, 32'hAABB_CCDD, 4'b0010, a, e);
    xfer(0, "rd20", 1'b0, B + 32'h20, 32'd0, 4'b0001, a, e);
    check("merge_dat", dat_of(0), 32'h1122_CC44);
    xfer(0, "wr20z", 1'b1, B + 32'h20, 32'hFFFF_FFFF, 4'b0000, a, e);
    check("sel0_ack", 32'(a), 32'd1);
    xfer(0, "rd20z", 1'b0, B + 32'h20, 32'd0, 4'hF, a, e);
    check("sel0_dat", dat_of(0), 32'h1122_CC44);

    // error decode
    xfer(0, "wr00", 1'b1, B, 32'h0102_0304, 4'hF, a, e);
    xfer(0, "rd00", 1'b0, B, 32'd0, 4'hF, a, e);
    check("rd00_dat", dat_of(0), 32'h0102_0304);
    xfer(0, "wroob", 1'b1, B + 32'd256, 32'hFFFF_FFFF, 4'hF, a, e);
    check("oob_ack", 32'(a), 32'd0);
    check("oob_err", 32'(e), 32'd1);
    xfer(0, "rdmis", 1'b0, B + 32'h2, 32'd0, 4'hF, a, e);
    check("mis_err", 32'(e), 32'd1);
    check("mis_dat_hold", dat_of(0), 32'h0102_0304);
    xfer(0, "rdlow", 1'b0, B - 32'd4, 32'd0, 4'hF, a, e);
    check("low_err", 32'(e), 32'd1);
    check("low_ack", 32'(a), 32'd0);
    xfer(0, "rd00b", 1'b0, B, 32'd0, 4'hF, a, e);
    check("oob_ram_intact", dat_of(0), 32'h0102_0304);
    xfer(0, "rd10b", 1'b0, B + 32'h10, 32'd0, 4'hF, a, e);
    check("good_after_err", dat_of(0), 32'hDEAD_BEEF);

    // back-to-back writes with stb held
    pat = 32'd0;
    k   = 0;
    drive(0, 1'b1, 1'b1, 1'b1, B + 32'h30, 32'hA0, 4'hF);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pat[i] = ack_of(0);
      if (ack_of(0)) begin
        k++;
        if (k < 3) begin
          drive(0, 1'b1, 1'b1, 1'b1, B + 32'h30 + 32'(4 * k),
                32'hA0 + 32'(k), 4'hF);
        end else begin
          drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        end
      end
    end
    check("b2b_pattern", pat, 32'h15);
    xfer(0, "rd30", 1'b0, B + 32'h30, 32'd0, 4'hF, a, e);
    check("b2b_w0", dat_of(0), 32'hA0);
    xfer(0, "rd34", 1'b0, B + 32'h34, 32'd0, 4'hF, a, e);
    check("b2b_w1", dat_of(0), 32'hA1);
    xfer(0, "rd38", 1'b0, B + 32'h38, 32'd0, 4'hF, a, e);
    check("b2b_w2", dat_of(0), 32'hA2);

    // wait states
    xfer(1, "ws_wr40", 1'b1, B + 32'h40, 32'h5555_5555, 4'hF, a, e);
    check("ws_wr_ack", 32'(a), 32'd1);

    // abort during WAIT
    flag = 1'b0;
    drive(1, 1'b1, 1'b1, 1'b1, B + 32'h40, 32'h6666_6666, 4'hF);
    repeat (2) begin
      @(negedge clk);
      flag = flag | ack_of(1) | err_of(1);
    end
    drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    repeat (6) begin
      @(negedge clk);
      flag = flag | ack_of(1) | err_of(1);
    end
    check("abort_quiet", 32'(flag), 32'd0);
    xfer(1, "ws_rd40", 1'b0, B + 32'h40, 32'd0, 4'hF, a, e);
    check("abort_old_data", dat_of(1), 32'h5555_5555);

    // reset during WAIT
    xfer(1, "ws_wr44", 1'b1, B + 32'h44, 32'h1234_5678, 4'hF, a, e);
    drive(1, 1'b1, 1'b1, 1'b1, B + 32'h44, 32'h8765_4321, 4'hF);
    @(negedge clk);
    rst1 = 1'b0;
    @(negedge clk);
    check("wrst_ack", 32'(ack_of(1)), 32'd0);
    check("wrst_err", 32'(err_of(1)), 32'd0);
    check("wrst_dat", dat_of(1), 32'd0);
    rst1 = 1'b1;
    drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    repeat (2) @(negedge clk);
    xfer(1, "ws_rd44", 1'b0, B + 32'h44, 32'd0, 4'hF, a, e);
    check("wrst_ram_intact", dat_of(1), 32'h1234_5678);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
